// File: rtl/alu_result_uart_tx.sv
// Buffers ALU result bytes in a small FIFO and sends each one as an 8N1 UART frame.
// tx comes straight from a flop, and reset drives it high asynchronously.
module alu_result_uart_tx #(
  parameter int CLKS_PER_BIT = 4,
  parameter int DEPTH        = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] res_data,
  input  logic       res_valid,
  output logic       res_ready,
  output logic       tx,
  output logic       busy,
  output logic       overflow
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BW-1:0] BAUD_LAST  = BW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state, state_nxt;
  logic [BW-1:0] baud, baud_nxt;
  logic [2:0]    bit_idx, bit_idx_nxt;
  logic [7:0]    shift, shift_nxt;
  logic          tx_reg, tx_nxt;
  logic          pop;
  logic          baud_done;

  logic [7:0]    mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          full, empty, push;

  assign full      = (count == FULL_COUNT);
  assign empty     = (count == '0);
  assign res_ready = !full;
  assign push      = res_valid && !full;
  assign tx        = tx_reg;
  assign busy      = (state != IDLE) || !empty;
  assign baud_done = (baud == BAUD_LAST);

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= res_data;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (res_valid && full) overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      baud    <= '0;
      bit_idx <= '0;
      shift   <= '0;
      tx_reg  <= 1'b1;
    end else begin
      state   <= state_nxt;
      baud    <= baud_nxt;
      bit_idx <= bit_idx_nxt;
      shift   <= shift_nxt;
      tx_reg  <= tx_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    baud_nxt    = baud;
    bit_idx_nxt = bit_idx;
    shift_nxt   = shift;
    tx_nxt      = tx_reg;
    pop         = 1'b0;
    case (state)
      IDLE: begin
        tx_nxt = 1'b1;
        if (!empty) begin
          pop       = 1'b1;
          shift_nxt = mem[rd_ptr];
          state_nxt = START;
          tx_nxt    = 1'b0;
          baud_nxt  = '0;
        end
      end
      START: begin
        if (baud_done) begin
          state_nxt   = DATA;
          bit_idx_nxt = '0;
          tx_nxt      = shift[0];
          baud_nxt    = '0;
        end else begin
          baud_nxt = baud + BW'(1);
        end
      end
      DATA: begin
        if (baud_done) begin
          baud_nxt = '0;
          if (bit_idx == 3'd7) begin
            state_nxt = STOP;
            tx_nxt    = 1'b1;
          end else begin
            shift_nxt   = shift >> 1;
            tx_nxt      = shift[1];
            bit_idx_nxt = bit_idx + 3'd1;
          end
        end else begin
          baud_nxt = baud + BW'(1);
        end
      end
      STOP: begin
        if (baud_done) begin
          baud_nxt = '0;
          // A waiting byte starts its frame right away, with no idle bit.
          if (!empty) begin
            pop       = 1'b1;
            shift_nxt = mem[rd_ptr];
            state_nxt = START;
            tx_nxt    = 1'b0;
          end else begin
            state_nxt = IDLE;
            tx_nxt    = 1'b1;
          end
        end else begin
          baud_nxt = baud + BW'(1);
        end
      end
      default: begin
        state_nxt = IDLE;
        tx_nxt    = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_alu_result_uart_tx.sv
// Randomised bench for alu_result_uart_tx, compared against a frame-level model.
// The model tracks a byte queue and the remaining cycles of the frame in flight.
module tb_alu_result_uart_tx;

  localparam int CPB   = 4;
  localparam int DEPTH = 4;
  localparam int FRAME = 10 * CPB;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] res_data = 8'h00;
  logic       res_valid = 1'b0;
  logic       res_ready, tx, busy, overflow;

  int total = 0;
  int bad   = 0;

  logic [7:0] byte_q[$];
  int         frame_left = 0;
  logic [7:0] cur_byte   = 8'h00;
  logic       m_ovf      = 1'b0;

  alu_result_uart_tx #(.CLKS_PER_BIT(CPB), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .res_data  (res_data),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .tx        (tx),
    .busy      (busy),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  // The model advances one step per edge, using the occupancy seen before that edge.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      byte_q.delete();
      frame_left = 0;
      m_ovf      = 1'b0;
    end else begin
      automatic bit ready  = (byte_q.size() < DEPTH);
      automatic bit do_pop = (byte_q.size() != 0) && (frame_left <= 1);
      if (frame_left > 0) frame_left--;
      if (do_pop) begin
        cur_byte   = byte_q.pop_front();
        frame_left = FRAME;
      end
      if (res_valid) begin
        if (ready) byte_q.push_back(res_data);
        else       m_ovf = 1'b1;
      end
    end
  end

  function automatic logic exp_tx();
    int p, b;
    if (frame_left == 0) return 1'b1;
    p = FRAME - frame_left;
    b = p / CPB;
    if (b == 0) return 1'b0;
    if (b == 9) return 1'b1;
    return cur_byte[b-1];
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic checkAll();
    checkOutput("tx", 32'(tx), 32'(exp_tx()));
    checkOutput("res_ready", 32'(res_ready), 32'(byte_q.size() < DEPTH));
    checkOutput("busy", 32'(busy), 32'((frame_left != 0) || (byte_q.size() != 0)));
    checkOutput("overflow", 32'(overflow), 32'(m_ovf));
  endtask

  task automatic applyStimulus(input logic v, input logic [7:0] d);
    @(negedge clk);
    checkAll();
    res_valid = v;
    res_data  = d;
  endtask

  task automatic idleCycles(input int n);
    repeat (n) applyStimulus(1'b0, 8'($urandom));
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_tx"}, 32'(tx), 32'd1);
    checkOutput({tag, "_ready"}, 32'(res_ready), 32'd1);
    checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
    checkOutput({tag, "_ovf"}, 32'(overflow), 32'd0);
  endtask

  // rst rises between edges, so its effect on tx is visible before the next clock.
  task automatic doReset(input int hold);
    @(negedge clk);
    checkAll();
    #1 rst = 1'b1;
    #1 checkResetValues("rst_async");
    repeat (hold) begin
      @(negedge clk);
      checkResetValues("rst_hold");
      res_valid = 1'($urandom);
      res_data  = 8'($urandom);
    end
    @(negedge clk);
    checkResetValues("rst_release");
    rst       = 1'b0;
    res_valid = 1'b0;
  endtask

  initial begin
    int rate;
    repeat (2) @(negedge clk);
    checkResetValues("por");
    rst = 1'b0;

    applyStimulus(1'b1, 8'hA5);
    idleCycles(50);

    applyStimulus(1'b1, 8'h01);
    applyStimulus(1'b1, 8'h02);
    applyStimulus(1'b1, 8'h03);
    idleCycles(130);

    for (int i = 0; i < 6; i++) applyStimulus(1'b1, 8'(8'h10 + i));
    idleCycles(210);
    checkOutput("ovf_sticky", 32'(overflow), 32'd1);

    doReset(2);
    for (int i = 0; i < 6; i++) applyStimulus(1'b1, 8'(8'h20 + i));
    for (int i = 0; i < 120; i++) applyStimulus(1'b1, 8'($urandom));
    idleCycles(220);

    doReset(1);
    applyStimulus(1'b1, 8'hFF);
    applyStimulus(1'b1, 8'h11);
    applyStimulus(1'b1, 8'h22);
    applyStimulus(1'b0, 8'h00);
    idleCycles(17);
    doReset(3);
    idleCycles(60);

    for (int seg = 0; seg < 8; seg++) begin
      case (seg % 4)
        0: rate = 10;
        1: rate = 40;
        2: rate = 95;
        default: rate = 3;
      endcase
      repeat (400) begin
        if ($urandom_range(0, 599) == 0) doReset($urandom_range(1, 3));
        else applyStimulus(($urandom_range(0, 99) < rate), 8'($urandom));
      end
    end
    idleCycles(250);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_result_uart_tx.md
# alu_result_uart_tx

Downstream stage of the 4-bit ALU top: captures each 8-bit ALU result (the ALU's uo_out byte) presented with a valid strobe, buffers it in a small FIFO and transmits it as an 8N1 UART frame on a single serial line. This lets the ALU run at full clock rate while results leave the chip on one pin. The block is fully self-timed by a parameterised baud divider.

## Interface

Parameters:
- CLKS_PER_BIT, default 4: clock cycles per serial bit; legal range 2..65535.
- DEPTH, default 4: FIFO entries; power of two, 2..16.

Ports:
- clk  input  1  single clock; all state changes on its rising edge.
- rst  input  1  reset, asynchronous, active-high; one clock, async active-high reset.
- res_data  input  8  ALU result byte to transmit.
- res_valid  input  1  res_data is valid this cycle.
- res_ready  output  1  FIFO can accept; high when not full.
- tx  output  1  UART serial output; idle high.
- busy  output  1  high while the FIFO is non-empty or a frame is in flight.
- overflow  output  1  sticky; set when a result is offered while the FIFO is full.

## Operation

- Push: on a rising edge with res_valid && res_ready, res_data is written at the FIFO tail. res_ready = !full, combinational from the registered count only; a same-cycle pop does not raise it.
- Offer while full (res_valid && !res_ready): byte dropped, overflow set to 1 on that edge; overflow clears only on rst.
- FSM states IDLE, START, DATA, STOP; registers: state, baud counter (0..CLKS_PER_BIT-1), bit index (0..7), 8-bit shift register, registered tx.
- IDLE: tx=1. If FIFO non-empty at an edge: pop head into shift register, state→START, tx→0, baud counter→0.
- START: after CLKS_PER_BIT cycles, state→DATA, bit index→0, tx←shift[0].
- DATA: every CLKS_PER_BIT cycles shift right, send next bit, LSB first; after bit 7's full period, state→STOP, tx→1.
- STOP: after CLKS_PER_BIT cycles, if FIFO non-empty pop and go straight to START (no idle gap), else go IDLE.
- Push and pop on the same edge: both take effect; count unchanged; pointers wrap modulo DEPTH.
- busy = (state != IDLE) || (count != 0).

## Timing

- Reset values: tx=1, res_ready=1, busy=0, overflow=0; state IDLE; FIFO empty; counters 0.
- Reset mid-frame: tx forced high immediately (asynchronously); FIFO contents discarded; no partial frame resumes after release.
- Latency: byte accepted at edge N into an empty FIFO with FSM in IDLE → tx falls after edge N+1.
- Frame length exactly 10×CLKS_PER_BIT cycles: 1 start, 8 data, 1 stop.
- Back-to-back frames: next start bit begins on the cycle immediately after the last stop-bit cycle.
- Sustained throughput: one byte per 10×CLKS_PER_BIT cycles; up to DEPTH+1 bytes held (DEPTH in FIFO, 1 in shift register).
- tx is driven directly from a flop; no combinational path from inputs to tx.

## Test plan

- Reset: assert rst mid-simulation with random inputs → tx=1, res_ready=1, busy=0, overflow=0 during and after reset.
- Single byte 0xA5, CLKS_PER_BIT=4 → tx low 2 clocks after acceptance; sampled bits 1,0,1,0,0,1,0,1 each held 4 cycles; stop high; busy drops after 40 cycles.
- Burst 0x01,0x02,0x03 on consecutive cycles → three frames, no idle gap between them, bytes in order, total 120 cycles of activity.
- Overflow, DEPTH=4: push 6 bytes on consecutive cycles → first byte moves to the shift register, next 4 fill the FIFO, 6th dropped with res_ready=0; overflow=1 and stays set; 5 frames sent.
- Simultaneous push/pop: FIFO full, offer a byte on the stop→start edge → rejected (res_ready=0 that cycle); offered the next cycle → accepted.
- Reset during DATA bit 3 of 0xFF with 2 bytes queued → tx=1 immediately; no further frames after rst release.
